reg_file_multiport: RTL
=======================

REG_FILE_MULTIPORT -- requirements
Module: reg_file_multiport

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 32: register width in bits.
- ADDR_WIDTH, default 5: address width; depth is 2**ADDR_WIDTH.
- ZERO_REG, default 1: when 1, register 0 reads as zero and ignores writes.
- BYPASS, default 1: when 1, same-cycle write data is forwarded to reads.

REQ-002 There SHALL be one clock and the reset SHALL be synchronous and active-high. Ports are, in order:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- readAddress0  input  ADDR_WIDTH  read port 0 address.
- readAddress1  input  ADDR_WIDTH  read port 1 address.
- writeAddress0  input  ADDR_WIDTH  write port 0 address.
- writeData0  input  DATA_WIDTH  write port 0 data.
- writeEnable0  input  1  write port 0 enable.
- writeAddress1  input  ADDR_WIDTH  write port 1 address.
- writeData1  input  DATA_WIDTH  write port 1 data.
- writeEnable1  input  1  write port 1 enable.
- busySet  input  1  mark register busyAddress pending.
- busyAddress  input  ADDR_WIDTH  scoreboard set address.
- readData0  output  DATA_WIDTH  read port 0 data.
- readData1  output  DATA_WIDTH  read port 1 data.
- readBusy0  output  1  pending flag of readAddress0.
- readBusy1  output  1  pending flag of readAddress1.

Function
REQ-003 Storage SHALL be 2**ADDR_WIDTH registers of DATA_WIDTH bits each, plus one busy bit per register.

REQ-004 On a rising edge with writeEnableN=1, the block SHALL store writeDataN at writeAddressN. Latency is 1 cycle to the array.

REQ-005 When both write ports are enabled to the same address, port 1 SHALL win and port 0 data is discarded.

REQ-006 With ZERO_REG=1, writes to address 0 SHALL be ignored, and address 0 SHALL read 0 and never be busy.

REQ-007 Reads SHALL be combinational (zero latency) from the array. Each read port is independent, and both ports may read the same address.

REQ-008 Forwarding with BYPASS=1: if a read address matches an enabled write address (and is not the zeroed address 0), readDataN SHALL show that write data in the same cycle. Port 1 data has priority over port 0.

REQ-009 With BYPASS=0, readDataN SHALL show the pre-edge array value; written data becomes visible the cycle after the write.

REQ-010 On a rising edge with busySet=1, the busy bit at busyAddress SHALL be set.

REQ-011 On a rising edge, any enabled write port SHALL clear the busy bit at its address.

REQ-012 If a set and a clear hit the same address on the same edge, the set SHALL win (the new producer takes precedence).

REQ-013 readBusyN SHALL equal busy[readAddressN]. With BYPASS=1 it SHALL be forced to 0 when an enabled write matches readAddressN in that cycle.

REQ-014 Address arithmetic SHALL be unsigned and never wraps: every ADDR_WIDTH value is a valid register. There is no out-of-range case.

REQ-015 There SHALL be no internal FSM beyond the array and the scoreboard. All outputs are combinational functions of state and inputs.

Reset
REQ-016 With reset=1 at a rising edge, all registers SHALL become 0 and all busy bits SHALL become 0.

REQ-017 Writes and busySet presented in a reset cycle SHALL be ignored. Reset takes priority over every simultaneous event.

REQ-018 After reset, readData0/1 SHALL be 0 and readBusy0/1 SHALL be 0 for every address, until the first post-reset write or set.

REQ-019 Reset asserted mid-operation (including the cycle right after busySet) SHALL leave no residual data or busy state.

Verification
REQ-020 Basic write/read: reset, then write 1 to r16 via port 0 and 3 to r17 via port 1 in the same cycle. Next cycle, readAddress0=16 and readAddress1=17 SHALL give 1 and 3.

REQ-021 Write disable: with both enables 0, present 4→r16 and 5→r17. Reads SHALL still give 1 and 3.

REQ-022 Write conflict: both ports write r8 (port 0: 0xAAAA, port 1: 0x5555). r8 SHALL read 0x5555. With ZERO_REG=1, writing 0xFFFF to r0 SHALL leave r0 reading 0.

REQ-023 Bypass: BYPASS=1, r9=7, then write 9 to r9 while reading r9. The same cycle SHALL show 9. With BYPASS=0, the same stimulus SHALL show 7, then 9 on the next cycle.

REQ-024 Scoreboard: busySet at r12 gives readBusy=1. Then write r12 and busySet r12 on the same edge: readBusy SHALL stay 1. A later write without a set SHALL clear it to 0.

REQ-025 Mid-operation reset: with r16=1 and r12 busy, assert reset together with a write of 6 to r16. Afterwards r16 SHALL read 0 and readBusy for r12 SHALL be 0.

Source files
------------

// File: rtl/reg_file_multiport.sv
// Two-read / two-write register file with a per-register busy scoreboard.
// Reads are combinational; optional same-cycle write forwarding and hard-wired zero register.
module reg_file_multiport #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] readAddress0,
  input  logic [ADDR_WIDTH-1:0] readAddress1,
  input  logic [ADDR_WIDTH-1:0] writeAddress0,
  input  logic [DATA_WIDTH-1:0] writeData0,
  input  logic                  writeEnable0,
  input  logic [ADDR_WIDTH-1:0] writeAddress1,
  input  logic [DATA_WIDTH-1:0] writeData1,
  input  logic                  writeEnable1,
  input  logic                  busySet,
  input  logic [ADDR_WIDTH-1:0] busyAddress,
  output logic [DATA_WIDTH-1:0] readData0,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic                  readBusy0,
  output logic                  readBusy1
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;

  logic                  wr0_ok;
  logic                  wr1_ok;
  logic [ADDR_WIDTH-1:0] raddr   [2];
  logic [DATA_WIDTH-1:0] rdata   [2];
  logic                  rbusy   [2];

  assign wr0_ok = writeEnable0 && !(ZERO_REG != 0 && writeAddress0 == '0);
  assign wr1_ok = writeEnable1 && !(ZERO_REG != 0 && writeAddress1 == '0);

  // Clears first, then the set, so a new producer overrides a retiring write.
  always_comb begin
    busy_d = busy_q;
    if (writeEnable0) busy_d[writeAddress0] = 1'b0;
    if (writeEnable1) busy_d[writeAddress1] = 1'b0;
    if (busySet)      busy_d[busyAddress]   = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      if (wr0_ok) regs_q[writeAddress0] <= writeData0;
      // Port 1 assigned last so it wins an address collision.
      if (wr1_ok) regs_q[writeAddress1] <= writeData1;
      busy_q <= busy_d;
    end
  end

  assign raddr[0] = readAddress0;
  assign raddr[1] = readAddress1;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = regs_q[raddr[p]];
      rbusy[p] = busy_q[raddr[p]];
      if (ZERO_REG != 0 && raddr[p] == '0) begin
        rdata[p] = '0;
        rbusy[p] = 1'b0;
      end else if (BYPASS != 0) begin
        if (writeEnable1 && writeAddress1 == raddr[p]) begin
          rdata[p] = writeData1;
          rbusy[p] = 1'b0;
        end else if (writeEnable0 && writeAddress0 == raddr[p]) begin
          rdata[p] = writeData0;
          rbusy[p] = 1'b0;
        end
      end
    end
  end

  assign readData0 = rdata[0];
  assign readData1 = rdata[1];
  assign readBusy0 = rbusy[0];
  assign readBusy1 = rbusy[1];

endmodule
